cpu_ctrl: RTL and testbench

Control/sequencing FSM that drives the register-file/ALU datapath. It fetches 16-bit instructions from a single-port synchronous SRAM, decodes them, and issues the datapath control signals: write, IMM_MUX, SRAM_OUT, RA_BUF, rSrc, rDst, aluOp, imm and pc. It consumes the datapath's register read data (dSrc, dDst) and ALU flags (psrOut). It owns the PC, the instruction register and the latched flag register, and it drives the shared instruction/data memory port.

---
 rtl/cpu_ctrl_if.sv | 37 +++
 rtl/cpu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cpu_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
// Bus between the sequencer and its datapath/SRAM. SRAM reads return data
// one cycle after mem_addr is presented; writes commit on the edge that ends mem_we.
interface cpu_ctrl_if #(
    parameter int DATAWIDTH  = 16,
    parameter int REGWIDTH   = 4,
    parameter int ALUOPWIDTH = 4,
    parameter int PSRWIDTH   = 5
);
    logic [DATAWIDTH-1:0]  mem_rdata;
    logic [DATAWIDTH-1:0]  dSrc;
    logic [DATAWIDTH-1:0]  dDst;
    logic [PSRWIDTH-1:0]   psrOut;
    logic [DATAWIDTH-1:0]  mem_addr;
    logic [DATAWIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic                  write;
    logic                  IMM_MUX;
    logic                  SRAM_OUT;
    logic                  RA_BUF;
    logic [REGWIDTH-1:0]   rSrc;
    logic [REGWIDTH-1:0]   rDst;
    logic [ALUOPWIDTH-1:0] aluOp;
    logic [DATAWIDTH-1:0]  imm;
    logic [DATAWIDTH-1:0]  pc;

    modport master (
        input  mem_rdata, dSrc, dDst, psrOut,
        output mem_addr, mem_wdata, mem_we, write, IMM_MUX, SRAM_OUT, RA_BUF,
               rSrc, rDst, aluOp, imm, pc
    );

    modport slave (
        output mem_rdata, dSrc, dDst, psrOut,
        input  mem_addr, mem_wdata, mem_we, write, IMM_MUX, SRAM_OUT, RA_BUF,
               rSrc, rDst, aluOp, imm, pc
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer for the register-file/ALU datapath.
// Owns pc, ir and the latched flags; all strobes are decoded from state.
module cpu_ctrl #(
    parameter int DATAWIDTH  = 16,
    parameter int REGWIDTH   = 4,
    parameter int ALUOPWIDTH = 4,
    parameter int PSRWIDTH   = 5
) (
    input  logic             clk,
    input  logic             reset,
    cpu_ctrl_if.master       bus,
    output logic [1:0]       o_dbg_state
);
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_MEMWB  = 2'd3
    } state_t;

    localparam logic [ALUOPWIDTH-1:0] ALU_CMP = 4'd2;
    localparam logic [ALUOPWIDTH-1:0] ALU_AND = 4'd3;
    localparam logic [ALUOPWIDTH-1:0] ALU_OR  = 4'd4;
    localparam logic [ALUOPWIDTH-1:0] ALU_XOR = 4'd5;
    localparam logic [DATAWIDTH-1:0]  PC_ONE  = 1;
    localparam logic [DATAWIDTH-1:0]  IR_NOP  = 16'hD000;
    localparam int F_C = 0;
    localparam int F_L = 1;
    localparam int F_F = 2;
    localparam int F_Z = 3;
    localparam int F_N = 4;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATAWIDTH-1:0]  r_pc;
    logic [DATAWIDTH-1:0]  w_next_pc;
    logic [DATAWIDTH-1:0]  r_ir;
    logic [PSRWIDTH-1:0]   r_psr;
    logic [PSRWIDTH-1:0]   w_next_psr;

    logic [3:0]            w_op;
    logic [3:0]            w_cond;
    logic                  w_is_rtype;
    logic                  w_is_itype;
    logic [ALUOPWIDTH-1:0] w_alu_op;
    logic                  w_zext;
    logic [DATAWIDTH-1:0]  w_imm;
    logic                  w_cond_true;

    logic [DATAWIDTH-1:0]  w_mem_addr;
    logic                  w_mem_we;
    logic                  w_write;
    logic                  w_imm_mux;
    logic                  w_sram_out;
    logic                  w_ra_buf;

    assign w_op       = r_ir[15:12];
    assign w_cond     = r_ir[11:8];
    assign w_is_rtype = (w_op == 4'h0);
    assign w_is_itype = (w_op >= 4'h1) && (w_op <= 4'h7);
    assign w_alu_op   = w_is_itype ? (w_op - 4'h1) : r_ir[7:4];
    // Only the logical immediates zero-extend; branch offsets share the sign-extend path.
    assign w_zext     = w_is_itype &&
                        ((w_alu_op == ALU_AND) || (w_alu_op == ALU_OR) || (w_alu_op == ALU_XOR));
    assign w_imm      = w_zext ? {{(DATAWIDTH-8){1'b0}}, r_ir[7:0]}
                               : {{(DATAWIDTH-8){r_ir[7]}}, r_ir[7:0]};

    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            4'h0: w_cond_true =  r_psr[F_Z];
            4'h1: w_cond_true = ~r_psr[F_Z];
            4'h2: w_cond_true =  r_psr[F_C];
            4'h3: w_cond_true = ~r_psr[F_C];
            4'h4: w_cond_true =  r_psr[F_L];
            4'h5: w_cond_true = ~r_psr[F_L];
            4'h6: w_cond_true =  r_psr[F_N];
            4'h7: w_cond_true = ~r_psr[F_N];
            4'h8: w_cond_true =  r_psr[F_F];
            4'h9: w_cond_true = ~r_psr[F_F];
            4'hE: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= IR_NOP;
            r_psr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_psr   <= w_next_psr;
            if (r_state == S_DECODE) begin
                r_ir <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_psr   = r_psr;
        w_mem_addr   = r_pc;
        w_mem_we     = 1'b0;
        w_write      = 1'b0;
        w_imm_mux    = 1'b0;
        w_sram_out   = 1'b0;
        w_ra_buf     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = S_EXEC;
                w_next_pc    = r_pc + PC_ONE;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                if (w_is_rtype) begin
                    w_write    = (w_alu_op != ALU_CMP);
                    w_next_psr = bus.psrOut;
                end else if (w_is_itype) begin
                    w_imm_mux  = 1'b1;
                    w_write    = (w_op != 4'h3);
                    w_next_psr = bus.psrOut;
                end else begin
                    case (w_op)
                        4'h8: begin
                            w_mem_addr   = bus.dSrc;
                            w_next_state = S_MEMWB;
                        end
                        4'h9: begin
                            w_mem_addr = bus.dSrc;
                            w_mem_we   = 1'b1;
                        end
                        4'hA: begin
                            if (w_cond_true) w_next_pc = r_pc + w_imm;
                        end
                        // Return address is the already-incremented pc; target is pre-write dSrc.
                        4'hB: begin
                            w_ra_buf  = 1'b1;
                            w_write   = 1'b1;
                            w_next_pc = bus.dSrc;
                        end
                        4'hC: begin
                            if (w_cond_true) w_next_pc = bus.dSrc;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEMWB: begin
                w_next_state = S_FETCH;
                w_sram_out   = 1'b1;
                w_write      = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = bus.dDst;
    assign bus.mem_we    = w_mem_we;
    assign bus.write     = w_write;
    assign bus.IMM_MUX   = w_imm_mux;
    assign bus.SRAM_OUT  = w_sram_out;
    assign bus.RA_BUF    = w_ra_buf;
    assign bus.rSrc      = r_ir[3:0];
    assign bus.rDst      = r_ir[11:8];
    assign bus.aluOp     = w_alu_op;
    assign bus.imm       = w_imm;
    assign bus.pc        = r_pc;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: a vector table of single instructions run from
// reset, plus hand-written sequences for reset abort, LOAD, branches and pc wrap.
module tb_cpu_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, stores captured for checking
  logic [15:0] mem [0:65535];
  int          st_count = 0;
  logic [15:0] st_addr;
  logic [15:0] st_data;

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) begin
      st_count <= st_count + 1;
      st_addr  <= bus.mem_addr;
      st_data  <= bus.mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] d_src;
    logic [15:0] d_dst;
    logic [4:0]  psr_in;
    logic        chk_mem;
    logic [15:0] e_addr;
    logic        e_we;
    logic        e_write;
    logic        e_imm_mux;
    logic        e_ra;
    logic [3:0]  e_rdst;
    logic [3:0]  e_aluop;
    logic [15:0] e_imm;
    logic [15:0] e_next;
  } vec_t;

  vec_t vecs [15];

  initial begin
    reset     = 1'b1;
    bus.dSrc   = '0;
    bus.dDst   = '0;
    bus.psrOut = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hD000;

    //          instr     dSrc      dDst      psr    mem   addr      we    wr    imm   ra    rdst  alu   imm       next
    vecs[0]  = '{16'h1305, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 16'h0005, 16'h0001};
    vecs[1]  = '{16'h13FB, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 16'hFFFB, 16'h0001};
    vecs[2]  = '{16'h43FB, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h3, 16'h00FB, 16'h0001};
    vecs[3]  = '{16'h0102, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 16'h0002, 16'h0001};
    vecs[4]  = '{16'h0125, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 16'h0025, 16'h0001};
    vecs[5]  = '{16'h3105, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 4'h2, 16'h0005, 16'h0001};
    vecs[6]  = '{16'h7280, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'h6, 16'hFF80, 16'h0001};
    vecs[7]  = '{16'h6345, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h5, 16'h0045, 16'h0001};
    vecs[8]  = '{16'h9201, 16'h0050, 16'hBEEF, 5'h00, 1'b1, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 16'h0001, 16'h0001};
    vecs[9]  = '{16'hB703, 16'h0100, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 4'h0, 16'h0003, 16'h0100};
    vecs[10] = '{16'hCE03, 16'h0200, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 16'h0003, 16'h0200};
    vecs[11] = '{16'hC003, 16'h0200, 16'h0000, 5'h08, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0003, 16'h0001};
    vecs[12] = '{16'hAE05, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 16'h0005, 16'h0006};
    vecs[13] = '{16'hAFFE, 16'h0000, 16'h0000, 5'h1F, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 16'hFFFE, 16'h0001};
    vecs[14] = '{16'hD123, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 16'h0023, 16'h0001};

    // Reset state
    do_reset;
    chk16("rst_state", 16'(dbg_state), 16'h0000);
    chk16("rst_pc", bus.pc, 16'h0000);
    chk16("rst_addr", bus.mem_addr, 16'h0000);
    chk16("rst_strobes", 16'({bus.write, bus.mem_we, bus.IMM_MUX, bus.SRAM_OUT, bus.RA_BUF}), 16'h0000);
    chk16("rst_ir_nop_aluop", 16'(bus.aluOp), 16'h0000);

    // Vector table: each instruction at address 0 straight out of reset
    for (int i = 0; i < 15; i++) begin
      mem[0]     = vecs[i].instr;
      bus.dSrc   = vecs[i].d_src;
      bus.dDst   = vecs[i].d_dst;
      bus.psrOut = vecs[i].psr_in;
      do_reset;
      @(negedge clk);
      chk16($sformatf("v%0d_decode_strobes", i),
            16'({bus.write, bus.mem_we, bus.IMM_MUX, bus.SRAM_OUT, bus.RA_BUF}), 16'h0000);
      @(negedge clk);
      chk16($sformatf("v%0d_state", i), 16'(dbg_state), 16'h0002);
      chk1($sformatf("v%0d_we", i), bus.mem_we, vecs[i].e_we);
      chk1($sformatf("v%0d_write", i), bus.write, vecs[i].e_write);
      chk1($sformatf("v%0d_imm_mux", i), bus.IMM_MUX, vecs[i].e_imm_mux);
      chk1($sformatf("v%0d_ra_buf", i), bus.RA_BUF, vecs[i].e_ra);
      chk1($sformatf("v%0d_sram_out", i), bus.SRAM_OUT, 1'b0);
      chk16($sformatf("v%0d_rdst", i), 16'(bus.rDst), 16'(vecs[i].e_rdst));
      chk16($sformatf("v%0d_rsrc", i), 16'(bus.rSrc), 16'(vecs[i].instr[3:0]));
      chk16($sformatf("v%0d_aluop", i), 16'(bus.aluOp), 16'(vecs[i].e_aluop));
      chk16($sformatf("v%0d_imm", i), bus.imm, vecs[i].e_imm);
      chk16($sformatf("v%0d_pc", i), bus.pc, 16'h0001);
      if (vecs[i].chk_mem) begin
        chk16($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].e_addr);
        chk16($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].d_dst);
      end
      @(negedge clk);
      chk16($sformatf("v%0d_next_state", i), 16'(dbg_state), 16'h0000);
      chk16($sformatf("v%0d_next_addr", i), bus.mem_addr, vecs[i].e_next);
    end
    chk16("stor_count", 16'(st_count), 16'h0001);
    chk16("stor_addr", st_addr, 16'h0050);
    chk16("stor_data", st_data, 16'hBEEF);

    // Reset asserted during EXEC of ADD abandons the write at once
    mem[0]     = 16'h0102;
    bus.dSrc   = '0;
    bus.psrOut = '0;
    do_reset;
    @(negedge clk);
    @(negedge clk);
    chk1("abort_pre_write", bus.write, 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort_write", bus.write, 1'b0);
    chk16("abort_pc", bus.pc, 16'h0000);
    chk16("abort_state", 16'(dbg_state), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    chk16("abort_addr", bus.mem_addr, 16'h0000);
    @(negedge clk);
    chk16("abort_resume", 16'(dbg_state), 16'h0001);

    // LOAD: 4-cycle instruction with MEMWB write-back
    mem[0]     = 16'h8201;
    mem[16'h0040] = 16'h1234;
    bus.dSrc   = 16'h0040;
    do_reset;
    @(negedge clk);
    @(negedge clk);
    chk16("ld_exec_addr", bus.mem_addr, 16'h0040);
    chk1("ld_exec_we", bus.mem_we, 1'b0);
    chk1("ld_exec_write", bus.write, 1'b0);
    chk1("ld_exec_sram", bus.SRAM_OUT, 1'b0);
    @(negedge clk);
    chk16("ld_wb_state", 16'(dbg_state), 16'h0003);
    chk1("ld_wb_sram", bus.SRAM_OUT, 1'b1);
    chk1("ld_wb_write", bus.write, 1'b1);
    chk1("ld_wb_ra", bus.RA_BUF, 1'b0);
    chk1("ld_wb_we", bus.mem_we, 1'b0);
    chk16("ld_wb_rdst", 16'(bus.rDst), 16'h0002);
    chk16("ld_wb_rdata", bus.mem_rdata, 16'h1234);
    @(negedge clk);
    chk16("ld_next_state", 16'(dbg_state), 16'h0000);
    chk16("ld_next_addr", bus.mem_addr, 16'h0001);
    chk1("ld_next_sram", bus.SRAM_OUT, 1'b0);

    // CMPI then BEQ back, first with Z set, then with Z clear
    mem[0]        = 16'hCE00;
    mem[16'h0010] = 16'h3100;
    mem[16'h0011] = 16'hA0FE;
    bus.dSrc      = 16'h0010;
    bus.psrOut    = '0;
    do_reset;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk16("br_fetch_cmpi", bus.mem_addr, 16'h0010);
    bus.psrOut = 5'b01000;
    @(negedge clk);
    @(negedge clk);
    chk1("br_cmpi_write", bus.write, 1'b0);
    chk1("br_cmpi_immmux", bus.IMM_MUX, 1'b1);
    chk16("br_cmpi_pc", bus.pc, 16'h0011);
    @(negedge clk);
    bus.psrOut = 5'b00000;
    chk16("br_fetch_beq", bus.mem_addr, 16'h0011);
    @(negedge clk);
    @(negedge clk);
    chk16("br_beq_pc", bus.pc, 16'h0012);
    chk1("br_beq_write", bus.write, 1'b0);
    @(negedge clk);
    chk16("br_taken_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.psrOut = 5'b01000;
    chk16("br_fetch_beq2", bus.mem_addr, 16'h0011);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk16("br_not_taken_addr", bus.mem_addr, 16'h0012);

    // pc increment wraps from 0xFFFF to 0x0000
    mem[0]     = 16'hCE00;
    bus.dSrc   = 16'hFFFF;
    bus.psrOut = '0;
    do_reset;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk16("wrap_fetch", bus.mem_addr, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    chk16("wrap_pc", bus.pc, 16'h0000);
    @(negedge clk);
    chk16("wrap_next_addr", bus.mem_addr, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
